pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch.
- Issues one instruction-memory request at a time.
- Holds the returned fetch slot until decode accepts it.
- Advances the PC sequentially or redirects on a taken branch.
- Sits between the branch/ALU result path and the instruction memory; drives the PC value consumed by fetch and by branch-target adders.

Parameters:
XLEN, 64, PC and address width in bits
RESET_VECTOR, 64'h0, PC value loaded on reset
INSTR_BYTES, 4, sequential PC increment in bytes

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
branch_taken  input  1  redirect request, valid for one cycle
branch_target  input  XLEN  redirect address, sampled when branch_taken=1
stall  input  1  freeze: no new request issued while high
imem_req_valid  output  1  instruction-memory request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  XLEN  request address (equals pc_out while in REQ)
imem_resp_valid  input  1  response for the outstanding request
fetch_valid  output  1  fetch slot holds a live instruction for decode
fetch_ready  input  1  decode consumes the slot this cycle
fetch_pc  output  XLEN  PC of the instruction in the fetch slot
pc_out  output  XLEN  current architectural fetch PC

Behaviour:
- Reset (asynchronous, any state):
  - pc_out=RESET_VECTOR, fetch_pc=0.
  - imem_req_valid=0, fetch_valid=0, kill=0.
  - state=IDLE.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: outputs idle. Next cycle go to REQ unless stall=1.
  - REQ: imem_req_valid=1, imem_addr=pc_out.
    - On imem_req_ready=1: capture fetch_pc<=pc_out, go to WAIT.
    - stall=1 before acceptance: drop imem_req_valid and return to IDLE. Request retracted; legal only because not yet accepted.
  - WAIT: imem_req_valid=0, one request outstanding.
    - On imem_resp_valid=1 and kill=0: fetch_valid<=1, pc_out<=pc_out+INSTR_BYTES, go to HOLD.
    - On imem_resp_valid=1 and kill=1: discard response, clear kill, go to REQ, or IDLE if stall=1.
  - HOLD: fetch_valid=1.
    - On fetch_ready=1: fetch_valid<=0, go to REQ, or IDLE if stall=1.
    - Response-to-slot latency: 1 cycle. Back-to-back throughput: one instruction per 3 cycles minimum (REQ, WAIT, HOLD).
- Redirect (branch_taken=1), all states, one cycle:
  - pc_out<=branch_target.
  - Any fetch slot is squashed: fetch_valid<=0.
  - IDLE/REQ: next state REQ, or IDLE if stall=1. In REQ the new address is presented the following cycle. An acceptance in the same cycle as the redirect is treated as stale: go to WAIT with kill=1.
  - WAIT: kill<=1, stay in WAIT. A response arriving in the same cycle is also discarded.
  - HOLD: slot dropped even if fetch_ready=1 that cycle. Next state REQ.
- Branch wins over sequential increment when both would update pc_out in one cycle.
- stall never drops an accepted request or a valid slot. It only gates entry to REQ.
- Arithmetic: PC increment is modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0 silently.
- fetch_pc is stable while fetch_valid=1.

Optional Feature:
PC_MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign_err (1 bit, sticky until reset).
  - branch_target with low log2(INSTR_BYTES) bits nonzero sets misalign_err=1.
  - The redirect is ignored: pc_out unchanged, no squash.
- Undefined:
  - Low log2(INSTR_BYTES) bits of branch_target are forced to zero before loading pc_out.
  - No misalign_err port exists.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum (IDLE, REQ, WAIT, HOLD).
  - XLEN default.
  - RESET_VECTOR default.
  - INSTR_BYTES constant and its log2 alignment-mask width.
- One natural sub-module, pc_next_calc (combinational): selects pc_out+INSTR_BYTES vs aligned branch_target and generates the misalign flag. FSM and registers stay in the top.

Test Plan:
- Reset mid-WAIT with imem_resp_valid pulsed next cycle -> pc_out=RESET_VECTOR, fetch_valid=0, response ignored, first new request addr=0.
- Sequential fetch, imem_req_ready and imem_resp_valid one cycle after request, fetch_ready=1 -> addresses 0,4,8,12; fetch_pc matches each; 3 cycles per instruction.
- branch_taken with target 0x100 while in WAIT -> late response discarded, fetch_valid stays 0, next imem_addr=0x100.
- branch_taken in HOLD with fetch_ready=1 same cycle -> slot dropped, no handshake completes, next request addr=target.
- stall=1 held in HOLD -> fetch_valid stays 1 until fetch_ready, then IDLE; no imem_req_valid until stall=0.
- PC=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0. With PC_MISALIGN_TRAP_EN, target 0x102 -> misalign_err=1, pc_out unchanged. Without it, pc_out=0x100.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared state encoding and default parameters for the PC fetch sequencer.
package pc_seq_pkg;

    localparam int          XLEN_DEF         = 64;
    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
    localparam int          INSTR_BYTES_DEF  = 4;
    localparam int          ALIGN_BITS_DEF   = $clog2(INSTR_BYTES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection between the sequential increment and the aligned branch target.
// With PC_MISALIGN_TRAP_EN a misaligned target is flagged and the redirect suppressed.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int ALIGN_BITS  = ALIGN_BITS_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            redirect_o
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target_aligned;

    always_comb begin
        pc_inc         = pc_i + XLEN'(INSTR_BYTES);
        target_aligned = branch_target_i & ~LOW_MASK;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_o = branch_taken_i && ((branch_target_i & LOW_MASK) != '0);
        redirect_o = branch_taken_i && !misalign_o;
`else
        redirect_o = branch_taken_i;
`endif
        pc_next_o = redirect_o ? target_aligned : pc_inc;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer (PC_MISALIGN_TRAP_EN adds misalign_err).
// States: IDLE no request | REQ request presented | WAIT response outstanding | HOLD slot held for decode.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pc_out
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_next;
    logic            redirect;
    fetch_state_e    resume_state;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign;
    logic err_q, err_d;
`endif

    pc_next_calc #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .ALIGN_BITS  ($clog2(INSTR_BYTES))
    ) u_pc_next_calc (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_next_o       (pc_next),
        .redirect_o      (redirect)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_o      (misalign)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            kill_q        <= kill_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q | misalign;
    end

    assign misalign_err = err_q;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        kill_d        = kill_q;
        resume_state  = stall ? IDLE : REQ;

        if (redirect) begin
            pc_d          = pc_next;
            fetch_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = resume_state;
            end
            REQ: begin
                // An acceptance wins over stall; if it coincides with a redirect it fetches a stale address.
                if (imem_req_ready) begin
                    fetch_pc_d = pc_q;
                    kill_d     = redirect;
                    state_d    = WAIT;
                end else begin
                    state_d = resume_state;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = resume_state;
                    end else begin
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_next;
                        state_d       = HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = resume_state;
                end else if (fetch_ready) begin
                    fetch_valid_d = 1'b0;
                    state_d       = resume_state;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign pc_out         = pc_q;
    assign fetch_valid    = fetch_valid_q;
    assign fetch_pc       = fetch_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios with literal expectations plus randomized traffic.
// The reference model tracks abstract fetch facts (request presented, outstanding, stale, slot) rather than FSM states.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_pc;
    logic [63:0] pc_out;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_err;
    bit          m_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] m_pc;
    logic [63:0] m_fetch_pc;
    bit          m_pres;
    bit          m_out;
    bit          m_stale;
    bit          m_slot;

    logic [63:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [63:0] con_q[$];

    pc_fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .pc_out          (pc_out)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%016h expected 0x%016h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 64'h0;
        m_fetch_pc = 64'h0;
        m_pres     = 1'b0;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_slot     = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        m_err      = 1'b0;
`endif
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_advance();
        bit br, acc, deliv, n_out, n_slot;
`ifdef PC_MISALIGN_TRAP_EN
        bit misal;
        misal = branch_taken && (branch_target[1:0] != 2'b00);
        br    = branch_taken && !misal;
        if (misal) m_err = 1'b1;
`else
        br    = branch_taken;
`endif
        acc    = m_pres && imem_req_ready;
        deliv  = m_out && imem_resp_valid && !m_stale && !br;
        n_out  = acc || (m_out && !imem_resp_valid);
        if (acc)        m_stale = br;
        else if (n_out) m_stale = m_stale || br;
        else            m_stale = 1'b0;
        n_slot = deliv || (m_slot && !fetch_ready && !br);
        if (acc) m_fetch_pc = m_pc;
        if (br)         m_pc = {branch_target[63:2], 2'b00};
        else if (deliv) m_pc = m_pc + 64'd4;
        m_out  = n_out;
        m_slot = n_slot;
        m_pres = !stall && !n_out && !n_slot;
    endtask

    task automatic compare_outputs();
        chk("pc_out", pc_out, m_pc);
        chk("imem_req_valid", {63'b0, imem_req_valid}, {63'b0, m_pres});
        if (m_pres) chk("imem_addr", imem_addr, m_pc);
        chk("fetch_valid", {63'b0, fetch_valid}, {63'b0, m_slot});
        if (m_slot) chk("fetch_pc", fetch_pc, m_fetch_pc);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign_err", {63'b0, misalign_err}, {63'b0, m_err});
`endif
    endtask

    task automatic tick();
        #1;
        compare_outputs();
        if (imem_req_valid && imem_req_ready) begin
            acc_q.push_back(imem_addr);
            acc_cyc_q.push_back(cyc);
        end
        if (fetch_valid && fetch_ready) con_q.push_back(fetch_pc);
        @(posedge clk);
        model_advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        branch_taken    = 1'b0;
        branch_target   = 64'h0;
        stall           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        fetch_ready     = 1'b0;
    endtask

    task automatic goto_wait();
        for (int i = 0; i < 10 && !m_out; i++) begin
            quiet_inputs();
            imem_req_ready = 1'b1;
            fetch_ready    = 1'b1;
            tick();
        end
        quiet_inputs();
        chk("goto_wait_bound", {63'b0, m_out}, 64'd1);
    endtask

    task automatic goto_hold();
        for (int i = 0; i < 10 && !m_slot; i++) begin
            quiet_inputs();
            imem_req_ready  = 1'b1;
            imem_resp_valid = m_out;
            tick();
        end
        quiet_inputs();
        chk("goto_hold_bound", {63'b0, m_slot}, 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc_out", pc_out, 64'h0);
        chk("rst_fetch_pc", fetch_pc, 64'h0);
        chk("rst_fetch_valid", {63'b0, fetch_valid}, 64'd0);
        chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        reset = 1'b0;

        // Sequential fetch with single-cycle memory and always-ready decode.
        acc_q.delete(); acc_cyc_q.delete(); con_q.delete();
        for (int i = 0; i < 13; i++) begin
            quiet_inputs();
            imem_req_ready  = 1'b1;
            imem_resp_valid = m_out;
            fetch_ready     = 1'b1;
            tick();
        end
        quiet_inputs();
        chk("seq_accept_count", 64'(acc_q.size() >= 4), 64'd1);
        chk("seq_consume_count", 64'(con_q.size() >= 4), 64'd1);
        if (acc_q.size() >= 4 && con_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("seq_addr", acc_q[i], 64'(4 * i));
                chk("seq_fetch_pc", con_q[i], 64'(4 * i));
            end
            for (int i = 0; i < 3; i++) chk("seq_spacing", 64'(acc_cyc_q[i+1] - acc_cyc_q[i]), 64'd3);
        end

        // Asynchronous reset while a response is outstanding.
        goto_wait();
        reset = 1'b1;
        #1;
        chk("arst_pc_out", pc_out, 64'h0);
        chk("arst_fetch_valid", {63'b0, fetch_valid}, 64'd0);
        chk("arst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        imem_resp_valid = 1'b1;
        tick();
        quiet_inputs();
        chk("arst_resp_ignored", {63'b0, fetch_valid}, 64'd0);
        chk("arst_first_req", {63'b0, imem_req_valid}, 64'd1);
        chk("arst_first_addr", imem_addr, 64'h0);

        // Redirect while waiting: the late response must be discarded.
        goto_wait();
        branch_taken  = 1'b1;
        branch_target = 64'h100;
        tick();
        quiet_inputs();
        imem_resp_valid = 1'b1;
        tick();
        quiet_inputs();
        chk("wait_br_slot", {63'b0, fetch_valid}, 64'd0);
        chk("wait_br_req", {63'b0, imem_req_valid}, 64'd1);
        chk("wait_br_addr", imem_addr, 64'h100);

        // Redirect in HOLD with decode ready in the same cycle.
        goto_hold();
        chk("hold_fetch_pc", fetch_pc, 64'h100);
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        fetch_ready   = 1'b1;
        tick();
        quiet_inputs();
        chk("hold_br_slot", {63'b0, fetch_valid}, 64'd0);
        chk("hold_br_req", {63'b0, imem_req_valid}, 64'd1);
        chk("hold_br_addr", imem_addr, 64'h200);

        // Stall held across HOLD: slot stays until consumed, then no new request.
        goto_hold();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_slot", {63'b0, fetch_valid}, 64'd1);
        end
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_req", {63'b0, imem_req_valid}, 64'd0);
            chk("stall_slot_empty", {63'b0, fetch_valid}, 64'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_req", {63'b0, imem_req_valid}, 64'd1);
        chk("stall_release_addr", imem_addr, 64'h204);

        // PC wrap at the top of the address space.
        branch_taken  = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        quiet_inputs();
        goto_hold();
        chk("wrap_fetch_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_ready = 1'b1;
        tick();
        quiet_inputs();
        chk("wrap_req", {63'b0, imem_req_valid}, 64'd1);
        chk("wrap_addr", imem_addr, 64'h0);

        // Misaligned branch target.
        branch_taken  = 1'b1;
        branch_target = 64'h102;
        tick();
        quiet_inputs();
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign_flag", {63'b0, misalign_err}, 64'd1);
        chk("misalign_pc", pc_out, 64'h0);
`else
        chk("misalign_aligned_pc", pc_out, 64'h100);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            stall           = ($urandom_range(0, 4) == 0);
            imem_req_ready  = $urandom_range(0, 1) == 1;
            imem_resp_valid = m_out && ($urandom_range(0, 1) == 1);
            fetch_ready     = ($urandom_range(0, 2) != 0);
            branch_taken    = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       branch_target = {32'h0, $urandom};
                1:       branch_target = {$urandom, $urandom};
                2:       branch_target = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
                default: branch_target = {48'h0, $urandom_range(0, 65535) & 16'hFFFC};
            endcase
            tick();
        end
        quiet_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
